exu_alu_iq: RTL and testbench
=============================

# exu_alu_iq

Four-entry ALU issue queue that feeds the execute-stage ALU in the LA64 core. It accepts decoded ALU micro-ops from dispatch and holds them until both source operands are available, capturing late operands from the common data bus (CDB). It then issues the oldest ready op as a one-hot `alu_op` with `src0`/`src1` to the ALU. The ALU registers its inputs, so this block also delays the issued destination tag by one cycle to align it with the ALU `result`.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries (power of two, 2..8)
- `TAG_W`, 6: physical destination/source tag width

Ports (`ALU_OP_WIDTH` = 14, one-hot; `LA64_DATA_WIDTH` = 64):
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: reset; one clock, reset is synchronous and active-high
- `flush` in 1: synchronous pipeline flush
- `disp_valid` in 1: dispatch op valid
- `disp_ready` out 1: queue can accept an op this cycle
- `disp_alu_op` in 14: one-hot ALU op (bit0 add … bit13 lui)
- `disp_tag` in TAG_W: destination tag
- `disp_src0_rdy` / `disp_src1_rdy` in 1: operand value already valid
- `disp_src0_tag` / `disp_src1_tag` in TAG_W: producer tag if not ready
- `disp_src0_val` / `disp_src1_val` in 64: operand value if ready
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_data` in 64: result broadcast
- `alu_op` out 14: to ALU; all-zero when not issuing
- `src0`, `src1` out 64: to ALU; zero when not issuing
- `iss_valid` out 1, `iss_tag` out TAG_W: issue this cycle
- `res_valid` out 1, `res_tag` out TAG_W: aligned with ALU `result`

## Operation
- Each entry holds: valid, op, dest tag, age order, and per-source rdy, tag, and 64-bit value.
- Allocation:
  - `disp_ready` = at least one entry invalid, using registered state only. A same-cycle issue does not free a slot for dispatch.
  - On `disp_valid & disp_ready & ~flush`, the op is written to the lowest-index free entry and marked youngest.
- Wakeup:
  - Each cycle with `cdb_valid`, every valid entry whose source is not ready and whose source tag equals `cdb_tag` captures `cdb_data` and sets rdy.
  - The same rule applies to the op being dispatched in that cycle, so the CDB is not missed on the dispatch edge.
  - Once rdy is set, the source value is frozen.
- Select:
  - Candidates are valid entries with both rdy bits set in registered state. A wakeup in the current cycle does not qualify the entry until the next cycle.
  - Among candidates, the oldest by dispatch order wins. Age is tracked with a DEPTH×DEPTH age matrix or equivalent; ties are impossible.
- Issue:
  - With a winner and `~flush`, `iss_valid`=1 and `alu_op`, `src0`, `src1`, `iss_tag` come combinationally from the winner.
  - The winner is invalidated at the next edge. The ALU always accepts; there is no backpressure.
  - With no winner, `iss_valid`=0 and `alu_op`, `src0`, `src1`, `iss_tag` are all 0.
- Result alignment: `res_valid`/`res_tag` are registered copies of `iss_valid`/`iss_tag`.
- Flush:
  - All entries are invalidated at the edge and a same-cycle dispatch is dropped.
  - `iss_valid` and `alu_op` are forced to 0 during the flush cycle, so `res_valid`=0 in the following cycle.
  - `res_valid` is also cleared at the flush edge.
- Reset: all entries invalid, age state cleared, `res_valid`=0 and `res_tag`=0. While `rst` is high, `disp_ready`=0 and `iss_valid`=0.

## Timing
- Dispatch with both sources ready at edge N: `iss_valid` in cycle N+1, `res_valid`+`res_tag` in N+2, coincident with ALU `result`.
- A CDB match at edge N makes that source ready from cycle N+1; issue is possible in N+1.
- Full queue: `disp_ready`=0 for the whole cycle even if an issue occurs; it rises the cycle after the freeing edge.
- Simultaneous dispatch and issue: both happen. The new op never issues in its dispatch cycle.
- A CDB tag matching both sources of one entry captures both.
- `rst` has priority over `flush`, and `flush` has priority over dispatch, wakeup and issue.

## Test plan
- Reset, then dispatch add with src0=5, src1=7 (both ready), tag 3 -> cycle+1: `alu_op`=0x0001, `iss_tag`=3; cycle+2: `res_valid`=1, `res_tag`=3, ALU `result`=12.
- Dispatch sub (tag 4) with src1 waiting on tag 9; two cycles later CDB tag 9 data 2 -> no issue before the CDB edge; issue the next cycle with `src1`=2.
- CDB tag 9 on the same edge as dispatch of an op waiting on tag 9 -> value captured; issue in the next cycle.
- Fill 4 ready-blocked entries -> `disp_ready`=0. Wake all with one CDB -> issues in dispatch order over 4 cycles; `disp_ready` returns the cycle after the first issue edge.
- Entry B younger than A; wake B first, then A, then both ready -> A issues before B once both are candidates.
- Two ops queued, assert `flush` for one cycle -> `iss_valid`=0 that cycle, no `res_valid` afterwards, `disp_ready`=1 next cycle, queue empty.

Source files
------------

// File: rtl/exu_alu_iq.sv
// ALU issue queue: holds dispatched ALU ops until both operands are ready, issues oldest-ready to the ALU.
// Latency: dispatch-with-ready-operands issues the next cycle; res_valid/res_tag follow issue by one cycle.
// Backpressure: disp_ready drops when every entry is occupied (registered state only); the ALU never stalls.
module exu_alu_iq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [13:0]      disp_alu_op,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             disp_src0_rdy,
    input  logic             disp_src1_rdy,
    input  logic [TAG_W-1:0] disp_src0_tag,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [63:0]      disp_src0_val,
    input  logic [63:0]      disp_src1_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [63:0]      cdb_data,
    output logic [13:0]      alu_op,
    output logic [63:0]      src0,
    output logic [63:0]      src1,
    output logic             iss_valid,
    output logic [TAG_W-1:0] iss_tag,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag
);

    localparam int OP_W   = 14;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } src_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        src_t             s0;
        src_t             s1;
    } ent_t;

    logic [DEPTH-1:0] ent_vld;
    ent_t             ent_q   [DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] older_q [DEPTH];

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] iss_oh;
    logic             disp_fire;
    ent_t             new_ent;

    function automatic src_t src_wake(input src_t s, input logic cv,
                                      input logic [TAG_W-1:0] ct,
                                      input logic [DATA_W-1:0] cd);
        src_t r;
        r = s;
        if (cv && !s.rdy && (s.tag == ct)) begin
            r.rdy = 1'b1;
            r.val = cd;
        end
        return r;
    endfunction

    assign alloc_oh   = ~ent_vld & (ent_vld + DEPTH'(1));
    assign disp_ready = ~rst & ~(&ent_vld);
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign iss_valid  = ~rst & ~flush & (|cand);
    assign iss_oh     = grant & {DEPTH{iss_valid}};

    always_comb begin
        src_t d0;
        src_t d1;
        d0 = '{rdy: disp_src0_rdy, tag: disp_src0_tag, val: disp_src0_val};
        d1 = '{rdy: disp_src1_rdy, tag: disp_src1_tag, val: disp_src1_val};
        new_ent.op  = disp_alu_op;
        new_ent.tag = disp_tag;
        new_ent.s0  = src_wake(d0, cdb_valid, cdb_tag, cdb_data);
        new_ent.s1  = src_wake(d1, cdb_valid, cdb_tag, cdb_data);
    end

    // Candidates use registered rdy only; an entry wins if no older candidate exists.
    always_comb begin
        cand  = '0;
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = ent_vld[i] & ent_q[i].s0.rdy & ent_q[i].s1.rdy;
        end
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && cand[j] && older_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        alu_op  = '0;
        src0    = '0;
        src1    = '0;
        iss_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_oh[i]) begin
                alu_op  = alu_op  | ent_q[i].op;
                src0    = src0    | ent_q[i].s0.val;
                src1    = src1    | ent_q[i].s1.val;
                iss_tag = iss_tag | ent_q[i].tag;
            end
        end
    end

    // Payload needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && alloc_oh[i]) begin
                ent_q[i] <= new_ent;
            end else begin
                ent_q[i].s0 <= src_wake(ent_q[i].s0, cdb_valid, cdb_tag, cdb_data);
                ent_q[i].s1 <= src_wake(ent_q[i].s1, cdb_valid, cdb_tag, cdb_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld   <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else if (flush) begin
            ent_vld   <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
        end else begin
            ent_vld   <= (ent_vld & ~iss_oh) | (alloc_oh & {DEPTH{disp_fire}});
            res_valid <= iss_valid;
            res_tag   <= iss_tag;
            // New entry is younger than every other slot, occupied or not.
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && alloc_oh[i]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        older_q[i][j] <= 1'b0;
                        if (j != i) begin
                            older_q[j][i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_exu_alu_iq.sv
// Directed bench for exu_alu_iq: hand-computed issue order, operand capture, flush and full-queue behaviour.
module tb_exu_alu_iq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [13:0] disp_alu_op = '0;
    logic [5:0]  disp_tag = '0;
    logic        disp_src0_rdy = 1'b0;
    logic        disp_src1_rdy = 1'b0;
    logic [5:0]  disp_src0_tag = '0;
    logic [5:0]  disp_src1_tag = '0;
    logic [63:0] disp_src0_val = '0;
    logic [63:0] disp_src1_val = '0;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic [13:0] alu_op;
    logic [63:0] src0;
    logic [63:0] src1;
    logic        iss_valid;
    logic [5:0]  iss_tag;
    logic        res_valid;
    logic [5:0]  res_tag;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] alu_sum;

    exu_alu_iq #(.DEPTH(4), .TAG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_alu_op(disp_alu_op), .disp_tag(disp_tag),
        .disp_src0_rdy(disp_src0_rdy), .disp_src1_rdy(disp_src1_rdy),
        .disp_src0_tag(disp_src0_tag), .disp_src1_tag(disp_src1_tag),
        .disp_src0_val(disp_src0_val), .disp_src1_val(disp_src1_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_op(alu_op), .src0(src0), .src1(src1),
        .iss_valid(iss_valid), .iss_tag(iss_tag),
        .res_valid(res_valid), .res_tag(res_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Start a new cycle: inputs change just after the falling edge.
    task automatic next_cyc();
        @(negedge clk);
        rst        = 1'b0;
        flush      = 1'b0;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
    endtask

    task automatic drv_disp(input int op, input int tag,
                            input bit r0, input int t0, input longint v0,
                            input bit r1, input int t1, input longint v1);
        disp_valid    = 1'b1;
        disp_alu_op   = 14'(op);
        disp_tag      = 6'(tag);
        disp_src0_rdy = r0;
        disp_src0_tag = 6'(t0);
        disp_src0_val = 64'(v0);
        disp_src1_rdy = r1;
        disp_src1_tag = 6'(t1);
        disp_src1_val = 64'(v1);
    endtask

    task automatic drv_cdb(input int tag, input longint data);
        cdb_valid = 1'b1;
        cdb_tag   = 6'(tag);
        cdb_data  = 64'(data);
    endtask

    task automatic chk_iss(input string nm, input bit v, input int tag);
        check({nm, "_iss_valid"}, 64'(iss_valid), 64'(v));
        if (v) check({nm, "_iss_tag"}, 64'(iss_tag), 64'(tag));
    endtask

    initial begin
        // Reset
        next_cyc(); rst = 1'b1; #1;
        check("rst_disp_ready", 64'(disp_ready), 64'd0);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        next_cyc(); rst = 1'b1; #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_tag", 64'(res_tag), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);

        // Ready add: issue next cycle, result tag the cycle after
        next_cyc(); drv_disp(14'h0001, 3, 1, 0, 5, 1, 0, 7); #1;
        check("add_disp_ready", 64'(disp_ready), 64'd1);
        chk_iss("add_c0", 0, 0);
        next_cyc(); #1;
        chk_iss("add_c1", 1, 3);
        check("add_alu_op", 64'(alu_op), 64'h0001);
        check("add_src0", src0, 64'd5);
        check("add_src1", src1, 64'd7);
        alu_sum = src0 + src1;
        next_cyc(); #1;
        check("add_res_valid", 64'(res_valid), 64'd1);
        check("add_res_tag", 64'(res_tag), 64'd3);
        check("add_result", alu_sum, 64'd12);
        chk_iss("add_c2", 0, 0);
        check("idle_alu_op", 64'(alu_op), 64'd0);
        check("idle_src0", src0, 64'd0);

        // Sub waiting on tag 9 for src1
        next_cyc(); drv_disp(14'h0002, 4, 1, 0, 10, 0, 9, 64'hdead); #1;
        next_cyc(); #1; chk_iss("sub_c1", 0, 0);
        next_cyc(); drv_cdb(9, 2); #1; chk_iss("sub_cdb_cycle", 0, 0);
        next_cyc(); #1;
        chk_iss("sub_c3", 1, 4);
        check("sub_alu_op", 64'(alu_op), 64'h0002);
        check("sub_src0", src0, 64'd10);
        check("sub_src1", src1, 64'd2);
        next_cyc(); #1;
        check("sub_res_tag", 64'(res_tag), 64'd4);
        chk_iss("sub_c4", 0, 0);

        // CDB on the dispatch edge
        next_cyc(); drv_disp(14'h0004, 5, 0, 11, 0, 1, 0, 3); drv_cdb(11, 64'h55); #1;
        next_cyc(); #1;
        chk_iss("samedge", 1, 5);
        check("samedge_src0", src0, 64'h55);
        check("samedge_src1", src1, 64'd3);

        // Fill four blocked entries, then wake them all at once
        for (int i = 0; i < 4; i++) begin
            next_cyc(); drv_disp(1 << (3 + i), 20 + i, 0, 30, 0, 1, 0, i); #1;
            check("fill_disp_ready", 64'(disp_ready), 64'd1);
        end
        next_cyc(); drv_cdb(30, 64'h100); #1;
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        chk_iss("full_noiss", 0, 0);
        next_cyc(); #1;
        chk_iss("drain0", 1, 20);
        check("drain0_alu_op", 64'(alu_op), 64'h0008);
        check("drain0_src0", src0, 64'h100);
        check("drain0_disp_ready", 64'(disp_ready), 64'd0);
        next_cyc(); #1;
        chk_iss("drain1", 1, 21);
        check("drain1_src1", src1, 64'd1);
        check("drain1_disp_ready", 64'(disp_ready), 64'd1);
        next_cyc(); #1; chk_iss("drain2", 1, 22);
        next_cyc(); #1; chk_iss("drain3", 1, 23);
        check("drain3_alu_op", 64'(alu_op), 64'h0040);
        next_cyc(); #1;
        chk_iss("drain_done", 0, 0);
        check("drain_res_tag", 64'(res_tag), 64'd23);

        // Age: B lands in a lower slot than older A; A must issue first
        next_cyc(); drv_disp(14'h0001, 39, 1, 0, 1, 1, 0, 1); #1;
        next_cyc(); drv_disp(14'h0010, 40, 0, 50, 0, 0, 52, 0); #1;
        chk_iss("age_x", 1, 39);
        next_cyc(); drv_disp(14'h0020, 41, 0, 51, 0, 0, 52, 0); #1;
        chk_iss("age_c2", 0, 0);
        next_cyc(); drv_cdb(51, 64'hb0); #1;
        next_cyc(); drv_cdb(50, 64'ha0); #1; chk_iss("age_c4", 0, 0);
        next_cyc(); drv_cdb(52, 64'hc0); #1; chk_iss("age_c5", 0, 0);
        next_cyc(); #1;
        chk_iss("age_first", 1, 40);
        check("age_first_src0", src0, 64'ha0);
        next_cyc(); #1;
        chk_iss("age_second", 1, 41);
        check("age_second_src0", src0, 64'hb0);
        check("age_second_src1", src1, 64'hc0);
        next_cyc(); #1;

        // Flush with two ready ops queued and a dispatch in the flush cycle
        next_cyc(); drv_disp(14'h0100, 60, 0, 63, 0, 1, 0, 1); #1;
        next_cyc(); drv_disp(14'h0200, 61, 0, 63, 0, 1, 0, 2); #1;
        next_cyc(); drv_cdb(63, 64'h77); #1;
        next_cyc(); flush = 1'b1; drv_disp(14'h0001, 62, 1, 0, 1, 1, 0, 1); #1;
        check("flush_iss_valid", 64'(iss_valid), 64'd0);
        check("flush_alu_op", 64'(alu_op), 64'd0);
        next_cyc(); #1;
        check("postflush_res_valid", 64'(res_valid), 64'd0);
        check("postflush_disp_ready", 64'(disp_ready), 64'd1);
        chk_iss("postflush_c1", 0, 0);
        next_cyc(); #1;
        chk_iss("postflush_c2", 0, 0);
        check("postflush_res_valid2", 64'(res_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
